// File: rtl/switch_hex_counter.sv
// switch_hex_counter
// Debounces a pair of raw push-switches (increment / decrement) and keeps an
// 8-bit wrap-around count. The count drives two seven-segment nibble decoders.
// A step is taken when a switch is released. o_Update pulses for one cycle
// whenever the count changes.
//
// Optional build macro: SWITCH_AUTO_REPEAT_EN
//   When it is defined, holding a switch produces extra steps. The first extra
//   step comes after REPEAT_DELAY held cycles. Further steps follow every
//   REPEAT_PERIOD cycles.
//   When it is undefined, no repeat logic is built and each press/release
//   gives exactly one step.
//
// Pipeline: p0/p1 form the synchroniser, p2 is the debounced level, p3 is the
// delayed level used for edge detection, and p4 holds the count and o_Update.

module switch_hex_counter #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_Inc,
    input  logic       i_Switch_Dec,
    output logic [3:0] o_Nibble_Upper,
    output logic [3:0] o_Nibble_Lower,
    output logic       o_Update
);

    localparam int DATA_W = 8;
    localparam int DB_W   = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);

    // Switch index 0 is increment, index 1 is decrement.
    logic [1:0] sw_raw;
    logic [1:0] sw_sync_p0;
    logic [1:0] sw_sync_p1;
    logic [1:0] sw_level_p2;
    logic [1:0] sw_level_p3;
    logic [1:0] rel_vld_p3;
    logic [1:0] rpt_vld_p2;
    logic [1:0] step_vld;

    logic [DATA_W-1:0] count_p4;
    logic              upd_vld_p4;

    assign sw_raw = {i_Switch_Dec, i_Switch_Inc};

    // Apply a signed step of +1, -1 or 0 to the count.
    // The result wraps modulo 2^DATA_W. Opposite requests cancel.
    function automatic logic [DATA_W-1:0] next_count(
        input logic [DATA_W-1:0] cur,
        input logic              inc,
        input logic              dec
    );
        logic signed [1:0]        dir;
        logic signed [DATA_W-1:0] delta;
        dir   = $signed({1'b0, inc}) - $signed({1'b0, dec});
        delta = {{(DATA_W-2){dir[1]}}, dir};
        return cur + $unsigned(delta);
    endfunction

    // ---- p0/p1: two-flop synchroniser for the asynchronous switch inputs
    // Bring both raw switches into the i_Clk domain.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sw_sync_p0 <= '0;
            sw_sync_p1 <= '0;
        end else begin
            sw_sync_p0 <= sw_raw;
            sw_sync_p1 <= sw_sync_p0;
        end
    end

    // ---- p2: per-switch debouncer
    for (genvar g = 0; g < 2; g++) begin : g_debounce
        logic [DB_W-1:0] db_cnt;
        logic            level;

        // Flip the debounced level only after DEBOUNCE_LIMIT consecutive
        // disagreeing cycles. Any agreeing cycle restarts the count.
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                db_cnt <= '0;
                level  <= 1'b0;
            end else if (sw_sync_p1[g] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end

        assign sw_level_p2[g] = level;
    end

`ifdef SWITCH_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    for (genvar g = 0; g < 2; g++) begin : g_repeat
        logic [RPT_W-1:0] rpt_cnt;
        logic             rpt_first;
        logic             rpt_hit;

        assign rpt_hit = sw_level_p2[g] &&
                         (rpt_cnt == (rpt_first ? RPT_FIRST : RPT_NEXT));
        assign rpt_vld_p2[g] = rpt_hit;

        // Count held cycles. The first wait is REPEAT_DELAY and later waits
        // are REPEAT_PERIOD. Everything is cleared as soon as the level drops.
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
            end else if (!sw_level_p2[g]) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
            end else if (rpt_hit) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
        end
    end
`else
    logic unused_repeat_cfg;

    assign rpt_vld_p2        = '0;
    // Keeps the repeat parameters referenced when auto-repeat is not built.
    assign unused_repeat_cfg = ^(REPEAT_DELAY ^ REPEAT_PERIOD);
`endif

    // ---- p3: delayed debounced level for release detection
    // Keep a one-cycle-old copy of each debounced level.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sw_level_p3 <= '0;
        end else begin
            sw_level_p3 <= sw_level_p2;
        end
    end

    assign rel_vld_p3 = sw_level_p3 & ~sw_level_p2;
    assign step_vld   = rel_vld_p3 | rpt_vld_p2;

    // ---- p4: count register and update strobe
    // Apply the step. A lone step changes the count and raises o_Update;
    // simultaneous inc and dec steps leave both the count and o_Update alone.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            count_p4   <= '0;
            upd_vld_p4 <= 1'b0;
        end else begin
            count_p4   <= next_count(count_p4, step_vld[0], step_vld[1]);
            upd_vld_p4 <= step_vld[0] ^ step_vld[1];
        end
    end

    assign o_Nibble_Upper = count_p4[DATA_W-1:DATA_W/2];
    assign o_Nibble_Lower = count_p4[DATA_W/2-1:0];
    assign o_Update       = upd_vld_p4;

endmodule

// File: tb/tb_switch_hex_counter.sv
// Testbench for switch_hex_counter.
// Expected counts are queued together with the cycle in which each update must
// appear. They are queued when a switch is pressed or released. Each o_Update
// pops one entry and compares it.
// Set SWITCH_AUTO_REPEAT_EN to match the build of the design.

module tb_switch_hex_counter;

    localparam int DEBOUNCE_LIMIT = 4;
    localparam int REPEAT_DELAY   = 20;
    localparam int REPEAT_PERIOD  = 8;
    localparam int RISE           = 2 + DEBOUNCE_LIMIT;      // press to debounced level
    localparam int LAT            = 2 + DEBOUNCE_LIMIT + 1;  // release to count change

    logic       i_Clk;
    logic       i_Rst;
    logic       i_Switch_Inc;
    logic       i_Switch_Dec;
    logic [3:0] o_Nibble_Upper;
    logic [3:0] o_Nibble_Lower;
    logic       o_Update;

    typedef struct {
        logic [7:0] cnt;
        int         at;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model;
    int         cyc;
    int         n_checks;
    int         n_pass;
    int         n_upd;

    switch_hex_counter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Switch_Inc  (i_Switch_Inc),
        .i_Switch_Dec  (i_Switch_Dec),
        .o_Nibble_Upper(o_Nibble_Upper),
        .o_Nibble_Lower(o_Nibble_Lower),
        .o_Update      (o_Update)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int shown();
        return int'({o_Nibble_Upper, o_Nibble_Lower});
    endfunction

    // Scoreboard: every update must match the oldest queued expectation.
    always @(negedge i_Clk) begin
        if (!i_Rst && o_Update) begin
            exp_t e;
            n_upd++;
            check_eq("upd_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("upd_count", shown(), int'(e.cnt));
                check_eq("upd_cycle", cyc, e.at);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic step_model(input logic inc);
        if (inc) model = model + 8'd1;
        else     model = model - 8'd1;
    endtask

    // Hold the given switches for 'hold' cycles, release them, then let the
    // pipeline settle. The expected steps are queued as the stimulus is driven.
    task automatic press(input logic inc, input logic dec, input int hold);
        int  e0;
        logic stepping;
        e0       = cyc;
        stepping = (hold >= DEBOUNCE_LIMIT) && (inc ^ dec);
        i_Switch_Inc = inc;
        i_Switch_Dec = dec;
`ifdef SWITCH_AUTO_REPEAT_EN
        if (stepping) begin
            for (int h = REPEAT_DELAY; h <= hold; h += REPEAT_PERIOD) begin
                step_model(inc);
                sb.push_back('{model, e0 + RISE + h});
            end
        end
`endif
        tick(hold);
        i_Switch_Inc = 1'b0;
        i_Switch_Dec = 1'b0;
        if (stepping) begin
            step_model(inc);
            sb.push_back('{model, cyc + LAT});
        end
        tick(LAT + 4);
    endtask

    initial begin
        int upd0;
        int exp_auto;
        int exp_auto_upd;
        n_checks     = 0;
        n_pass       = 0;
        n_upd        = 0;
        model        = 8'h00;
        i_Rst        = 1'b1;
        i_Switch_Inc = 1'b0;
        i_Switch_Dec = 1'b0;
        tick(3);
        check_eq("reset_upper", int'(o_Nibble_Upper), 0);
        check_eq("reset_lower", int'(o_Nibble_Lower), 0);
        check_eq("reset_update", int'(o_Update), 0);
        i_Rst = 1'b0;
        tick(2);

        // Single increment press
        upd0 = n_upd;
        press(1'b1, 1'b0, 10);
        check_eq("single_count", shown(), 8'h01);
        check_eq("single_updates", n_upd - upd0, 1);

        // Glitch shorter than the debounce window
        upd0 = n_upd;
        press(1'b1, 1'b0, 2);
        check_eq("glitch_count", shown(), 8'h01);
        check_eq("glitch_updates", n_upd - upd0, 0);

        // Decrement down through zero to 0xFF, then increment back up
        press(1'b0, 1'b1, 10);
        check_eq("dec_to_zero", shown(), 8'h00);
        press(1'b0, 1'b1, 10);
        check_eq("dec_wrap_upper", int'(o_Nibble_Upper), 4'hF);
        check_eq("dec_wrap_lower", int'(o_Nibble_Lower), 4'hF);
        press(1'b1, 1'b0, 10);
        check_eq("inc_wrap", shown(), 8'h00);

        // Simultaneous press and release cancel
        upd0 = n_upd;
        press(1'b1, 1'b1, 10);
        check_eq("simul_count", shown(), 8'h00);
        check_eq("simul_updates", n_upd - upd0, 0);

        // Ramp to 0x10, then hold increment long enough to auto-repeat
        while (model != 8'h10) press(1'b1, 1'b0, 6);
        check_eq("ramp_0x10", shown(), 8'h10);
`ifdef SWITCH_AUTO_REPEAT_EN
        exp_auto     = 8'h14;
        exp_auto_upd = 4;
`else
        exp_auto     = 8'h11;
        exp_auto_upd = 1;
`endif
        upd0 = n_upd;
        press(1'b1, 1'b0, 40);
        check_eq("auto_count", shown(), exp_auto);
        check_eq("auto_updates", n_upd - upd0, exp_auto_upd);

        // Ramp to 0x37, then assert reset asynchronously during a press
        while (model != 8'h37) press(1'b1, 1'b0, 6);
        check_eq("ramp_0x37", shown(), 8'h37);
        i_Switch_Inc = 1'b1;
        tick(3);
        #1;
        i_Rst = 1'b1;
        #1;
        check_eq("async_rst_upper", int'(o_Nibble_Upper), 0);
        check_eq("async_rst_lower", int'(o_Nibble_Lower), 0);
        check_eq("async_rst_update", int'(o_Update), 0);
        model = 8'h00;
        tick(2);
        i_Switch_Inc = 1'b0;
        tick(1);
        i_Rst = 1'b0;
        upd0 = n_upd;
        tick(LAT + 6);
        check_eq("post_rst_count", shown(), 0);
        check_eq("post_rst_updates", n_upd - upd0, 0);

        check_eq("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_hex_counter.md
Name: switch_hex_counter

Overview:
- Upstream source of the nibble values shown on the board's two seven-segment digits.
- Debounces two raw push-switches (increment, decrement) and keeps an 8-bit wrap-around count.
- Presents the count as upper and lower nibbles, each feeding one nibble-to-7SD decoder.
- Also emits a one-cycle update strobe whenever the count changes.

Parameters:
DEBOUNCE_LIMIT, 250000, consecutive cycles a raw switch must differ from its debounced level before that level flips (10 ms at 25 MHz); legal range >= 2.
REPEAT_DELAY, 12500000, cycles a switch must be held before the first auto-repeat step (only used with SWITCH_AUTO_REPEAT_EN).
REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat steps (only used with SWITCH_AUTO_REPEAT_EN).

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  asynchronous, active-high reset
i_Switch_Inc  input  1  raw increment switch, active-high, asynchronous to i_Clk
i_Switch_Dec  input  1  raw decrement switch, active-high, asynchronous to i_Clk
o_Nibble_Upper  output  4  count[7:4], registered
o_Nibble_Lower  output  4  count[3:0], registered
o_Update  output  1  one-cycle pulse, high in the cycle after the count changes

Behaviour:
- Clock and reset: one clock, i_Clk. Reset i_Rst is asynchronous and active-high.
- Reset values: count = 0x00, o_Update = 0, both debounced levels = 0, all debounce and repeat counters = 0.
- Reset may assert at any time. It aborts any in-progress debounce or repeat with no step emitted.
- Synchroniser: each raw switch passes through a 2-flop synchroniser before the debouncer.
- Debounce, per switch, independent:
  - Synchronised input == debounced level: counter clears to 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_LIMIT-1, the debounced level flips on that edge and the counter clears.
  - Glitches shorter than DEBOUNCE_LIMIT cycles never change the level.
- Step events:
  - A step is generated when a debounced level falls 1->0, i.e. on switch release.
  - The step is detected from the debounced level and its one-cycle-delayed copy.
  - The count updates on the clock edge after the debounced level falls.
- Count arithmetic: 8-bit modulo.
  - Increment wraps 0xFF->0x00.
  - Decrement wraps 0x00->0xFF.
- Simultaneous inc and dec steps in the same cycle: they cancel. Count unchanged, no o_Update.
- o_Update: asserts for exactly one cycle, the cycle in which the new count is first visible on the nibble outputs.
- Total latency from a raw release to the count change: 2 (synchroniser) + DEBOUNCE_LIMIT + 1 cycles.
- Nibble outputs are direct slices of the count register. No combinational path from the switches.

Optional Feature:
SWITCH_AUTO_REPEAT_EN
- Defined: a repeat counter runs per switch while its debounced level is 1.
  - First extra step fires when held REPEAT_DELAY cycles.
  - Further steps fire every REPEAT_PERIOD cycles while still held.
  - The counter clears when the level drops.
  - The release step is still issued.
  - Repeat steps obey the same wrap and cancellation rules and pulse o_Update.
- Not defined: no repeat logic is synthesised, and REPEAT_DELAY and REPEAT_PERIOD are ignored. Exactly one step occurs per press/release.

Test Plan (DEBOUNCE_LIMIT=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset check: assert i_Rst mid-run with count 0x37 -> outputs 0x0/0x0 and o_Update 0 immediately, without waiting for a clock edge.
- Single press: i_Switch_Inc high 10 cycles, then low -> count 0x00->0x01, one o_Update pulse, exactly 2+4+1 cycles after the release.
- Glitch rejection: i_Switch_Inc high 2 cycles, then low -> no count change, no o_Update.
- Decrement wrap and increment wrap:
  - Decrement from 0x00 -> 0xFF, nibbles 0xF/0xF.
  - Increment from 0xFF -> 0x00.
- Simultaneous release: release both switches on the same edge after a 10-cycle hold -> count unchanged, no o_Update.
- Auto-repeat (SWITCH_AUTO_REPEAT_EN): hold inc 40 cycles past debounce, then release, starting from 0x10:
  - Steps at held-cycles 20, 28 and 36.
  - Count reaches 0x14 after the release step, with 4 o_Update pulses.
  - Without the macro, the same stimulus gives 0x11.
